// File: rtl/switch_mcu_regfile_host.sv
// switch_mcu_regfile_host: byte-serial host command bridge and sole master of the MCU regfile port
module switch_mcu_regfile_host #(
   parameter int RD_LAT  = 1,
   parameter int TIMEOUT = 1024
) (
   input  logic        in_clk,
   input  logic        in_rst,
   input  logic [7:0]  in_cmd_data,
   input  logic        in_cmd_valid,
   output logic        out_cmd_ready,
   output logic [7:0]  out_rsp_data,
   output logic        out_rsp_valid,
   input  logic        in_rsp_ready,
   output logic [4:0]  out_addr,
   output logic [31:0] out_wdata,
   output logic        out_wr,
   input  logic [31:0] in_rdata,
   output logic        out_busy
);
   localparam int TMAX = TIMEOUT > RD_LAT ? TIMEOUT : RD_LAT;
   localparam int TW   = $clog2(TMAX + 1);
   typedef enum logic [2:0] {IDLE, GET_DATA, WRITE, READ_WAIT, RSP_HDR, RSP_DATA, ERR} state_t;
   state_t        state_q, state_d;
   logic [4:0]    addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d, sh_q, sh_d;
   logic [7:0]    hdr_q, hdr_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          cmd_acc, rsp_acc;
   // handshake outputs decode only registered state, so nothing combinational from the valids
   assign out_cmd_ready = state_q == IDLE || state_q == GET_DATA;
   assign out_rsp_valid = state_q inside {RSP_HDR, RSP_DATA, ERR};
   assign cmd_acc       = in_cmd_valid && out_cmd_ready;
   assign rsp_acc       = out_rsp_valid && in_rsp_ready;
   assign out_rsp_data  = state_q == RSP_HDR  ? hdr_q :
                          state_q == RSP_DATA ? sh_q[31:24] :
                          state_q == ERR      ? 8'hEE : 8'h00;
   assign out_wr        = state_q == WRITE && !in_rst;
   assign out_busy      = state_q != IDLE;
   assign out_addr      = addr_q;
   assign out_wdata     = wdata_q;
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      sh_d    = sh_q;
      hdr_d   = hdr_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      case (state_q)
         IDLE: if (cmd_acc) begin
            if (in_cmd_data[6:5] != 2'b00) state_d = ERR;
            else begin
               addr_d  = in_cmd_data[4:0];
               cnt_d   = 2'd0;
               tmr_d   = in_cmd_data[7] ? '0 : TW'(RD_LAT);
               state_d = in_cmd_data[7] ? GET_DATA : READ_WAIT;
            end
         end
         GET_DATA: if (cmd_acc) begin
            wdata_d = {wdata_q[23:0], in_cmd_data};
            tmr_d   = '0;
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = WRITE;
         end else begin
            tmr_d = tmr_q + TW'(1);
            if (tmr_d == TW'(TIMEOUT)) state_d = ERR;
         end
         WRITE: begin
            hdr_d   = 8'hA5;
            state_d = RSP_HDR;
         end
         READ_WAIT: if (tmr_q == '0) begin
            sh_d    = in_rdata;
            hdr_d   = 8'h5A;
            state_d = RSP_HDR;
         end else tmr_d = tmr_q - TW'(1);
         RSP_HDR: if (rsp_acc) begin
            cnt_d   = 2'd0;
            state_d = hdr_q == 8'h5A ? RSP_DATA : IDLE;
         end
         RSP_DATA: if (rsp_acc) begin
            sh_d  = {sh_q[23:0], 8'h00};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = IDLE;
         end
         ERR: if (rsp_acc) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         sh_q    <= '0;
         hdr_q   <= '0;
         cnt_q   <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         sh_q    <= sh_d;
         hdr_q   <= hdr_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
      end
   end
endmodule

// File: doc/switch_mcu_regfile_host.md
Name: switch_mcu_regfile_host

Overview:
Bus initiator for switch_mcu_regfile. It takes a byte-serial command stream from the host link, turns it into single read or write accesses on the regfile's address, write-data and write-strobe interface, and returns a byte-serial response. It sits between the host-side byte channel and the MCU register file and is the only master on that regfile port.

Parameters:
RD_LAT, 1, cycles from out_addr stable to in_rdata valid (0 = combinational read).
TIMEOUT, 1024, max idle cycles between write payload bytes before abort (≥2).

Ports:
in_clk  input  1  clock, all logic on the rising edge.
in_rst  input  1  synchronous, active-high reset.
in_cmd_data  input  8  command byte.
in_cmd_valid  input  1  command byte valid.
out_cmd_ready  output  1  command byte accepted when valid & ready.
out_rsp_data  output  8  response byte.
out_rsp_valid  output  1  response byte valid.
in_rsp_ready  input  1  response byte consumed when valid & ready.
out_addr  output  5  regfile address.
out_wdata  output  32  regfile write data.
out_wr  output  1  regfile write strobe, one cycle per write.
in_rdata  input  32  regfile read data.
out_busy  output  1  high whenever state != IDLE.

Behaviour:
- Opcode byte format: bit7 = 1 for write, 0 for read; bits6:5 are reserved and must be 00; bits4:0 give the address.
- Write command: opcode, then 4 data bytes MSB first. Response: 0xA5.
- Read command: opcode only. Response: 0x5A, then 4 data bytes MSB first.
- Error response: 0xEE.
- Reset: state IDLE; out_addr=0, out_wdata=0, out_wr=0, out_rsp_valid=0, out_rsp_data=0, out_busy=0. out_cmd_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation: the transaction is aborted. No out_wr pulse occurs in or after the reset cycle, and no partial response is emitted.
- States: IDLE, GET_DATA, WRITE, READ_WAIT, RSP_HDR, RSP_DATA, ERR.
- out_cmd_ready is high only in IDLE and GET_DATA. It is registered, so no combinational path from in_cmd_valid.
- IDLE, on an accepted opcode:
  - reserved bits nonzero -> ERR.
  - otherwise latch out_addr = bits4:0.
  - write -> GET_DATA with byte count 0.
  - read -> READ_WAIT with wait count RD_LAT.
- GET_DATA:
  - each accepted byte: out_wdata <= {out_wdata[23:0], byte}; idle counter cleared.
  - 4th byte accepted -> WRITE.
  - each cycle with no accepted byte increments the idle counter; idle counter == TIMEOUT -> ERR with no write.
- WRITE: out_wr=1 for exactly one cycle with out_addr and out_wdata stable, then RSP_HDR with header 0xA5.
  - Latency: last payload byte accepted in cycle N -> out_wr high in cycle N+1 -> out_rsp_valid in cycle N+2.
- READ_WAIT: out_addr held. in_rdata is captured into a 32-bit response shift register in cycle N+1+RD_LAT, where N is the opcode-accept cycle. Then RSP_HDR with header 0x5A; out_rsp_valid in cycle N+2+RD_LAT.
- RSP_HDR: out_rsp_valid=1 and out_rsp_data=header. On accept: read -> RSP_DATA, write -> IDLE.
- RSP_DATA: sends 4 bytes MSB first, one per accept. After the 4th accept -> IDLE.
- ERR: out_rsp_valid=1 and out_rsp_data=0xEE until accepted -> IDLE. No further command bytes are consumed while in ERR.
- Response handshake rules:
  - while out_rsp_valid=1 and in_rsp_ready=0, out_rsp_data must not change and valid must not drop.
  - back-to-back accepts give 1 byte per cycle.
  - out_rsp_valid falls in the cycle after the final accept.
- Command channel: in_cmd_valid is ignored when out_cmd_ready=0. Bytes are never lost or duplicated.
- out_addr and out_wdata hold their last values in IDLE. out_wr=0 in every state except WRITE.
- Address 0 and address 31 are legal; no range check.
- Earliest next opcode accept is the cycle after the last response byte is accepted.

Test Plan:
1. Write: cmd 0x81,0x00,0x00,0x12,0x34 -> exactly one out_wr pulse with out_addr=1 and out_wdata=0x00001234; then rsp 0xA5; out_busy returns to 0.
2. Read (RD_LAT=1, regfile model holds 0x2345 at address 2): cmd 0x02 -> rsp 0x5A,0x00,0x00,0x23,0x45; out_wr never asserts; timing matches N+2+RD_LAT.
3. Backpressure: repeat test 2 with in_rsp_ready toggling randomly -> identical byte sequence; data stable while stalled; no drops or repeats. Also hold in_cmd_valid with random gaps during a write -> same write result.
4. Reserved bits: cmd 0x41 -> rsp 0xEE; no out_wr; a following 0x01 read succeeds normally.
5. Timeout: cmd 0x83,0xAA then idle for TIMEOUT cycles -> rsp 0xEE; no out_wr; a subsequent full write to address 3 succeeds with the correct data.
6. Reset mid-write: assert in_rst after the 3rd payload byte -> no out_wr; all outputs read their reset values the next cycle; a fresh write after reset completes correctly.
